// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : dmem_pkg                                                      |
// | Description: Shared access-size codes, controller state encoding and the   |
// |              beat-count helper for the data-memory access controller.      |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  // Number of byte beats needed on the 8-bit memory for a given access size.
  // The illegal code never reaches the access phase; 1 keeps the result sane.
  function automatic logic [2:0] nbeats(input logic [1:0] size);
    case (size)
      SIZE_B:  nbeats = 3'd1;
      SIZE_H:  nbeats = 3'd2;
      SIZE_W:  nbeats = 3'd4;
      default: nbeats = 3'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dmem_load_extend                                              |
// | Description: Sign- or zero-extends an assembled little-endian load word    |
// |              according to the access size.                                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dmem_load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] rdata
);

  // Pick the sign source from the top bit of the accessed width.
  always_comb begin
    rdata = raw;
    case (size)
      SIZE_B:  rdata = {{24{~zero_ext & raw[7]}},  raw[7:0]};
      SIZE_H:  rdata = {{16{~zero_ext & raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dmem_access_ctrl                                              |
// | Description: Splits byte/half/word load-store requests into byte beats on  |
// |              an 8-bit single-port data memory, assembles and extends load  |
// |              data, and flags misaligned or illegal-size requests.          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rd
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        beat;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rbuf;
  logic [31:0]       ext_data;
  logic              accept;
  logic              req_err;
  logic              last_beat;

  assign accept    = req_valid && (state == ST_IDLE);
  assign req_err   = (req_size == SIZE_X) ||
                     ((req_size == SIZE_H) && req_addr[0]) ||
                     ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
  assign last_beat = ({1'b0, beat} == (nbeats(size_q) - 3'd1));

  // State register; reset lands in IDLE immediately, cutting any access short.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: bad requests skip the memory phase and go straight to response.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = req_err ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (last_beat) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request latches, beat counter and load byte lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat    <= 2'd0;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rbuf    <= 32'd0;
    end else if (accept) begin
      beat    <= 2'd0;
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      err_q   <= req_err;
      rbuf    <= 32'd0;
    end else if (state == ST_ACCESS) begin
      if (!we_q) rbuf[{beat, 3'b000} +: 8] <= mem_rd;
      beat <= beat + 2'd1;
    end
  end

  dmem_load_extend u_extend (
    .raw      (rbuf),
    .size     (size_q),
    .zero_ext (uns_q),
    .rdata    (ext_data)
  );

  // Outputs decode from registered state only, so nothing on req_* reaches memory.
  always_comb begin
    req_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'd0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    if (state == ST_ACCESS) begin
      mem_addr = addr_q + ADDR_W'(beat);
      if (we_q) begin
        mem_we    = 1'b1;
        mem_wdata = wdata_q[{beat, 3'b000} +: 8];
      end
    end
    if (state == ST_DONE) begin
      resp_valid = 1'b1;
      resp_err   = err_q;
      if (!we_q && !err_q) resp_rdata = ext_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_dmem_access_ctrl                                           |
// | Description: Directed self-checking bench for dmem_access_ctrl with a      |
// |              256-byte combinational-read memory attached.                  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err, busy, mem_we;
  logic [31:0] resp_rdata;
  logic [7:0]  mem_addr, mem_wdata, mem_rd;

  logic [7:0]  mem [0:255];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .busy         (busy),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd       (mem_rd)
  );

  // DataMemory stand-in: combinational read, synchronous byte write.
  assign mem_rd = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return 1 time unit after the accept edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wdata, input logic hold);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    step();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ".busy"},  {31'd0, busy},      32'd0);
    chk({tag, ".rv"},    {31'd0, resp_valid}, 32'd0);
    chk({tag, ".rdata"}, resp_rdata,          32'd0);
    chk({tag, ".err"},   {31'd0, resp_err},   32'd0);
    chk({tag, ".we"},    {31'd0, mem_we},     32'd0);
    chk({tag, ".addr"},  {24'd0, mem_addr},   32'd0);
    chk({tag, ".wdata"}, {24'd0, mem_wdata},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wexp;
    wexp = 32'hDEADBEEF;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;

    // Reset values
    step(); step();
    chk_idle_outputs("reset");
    rst = 1'b1;
    step();

    // Word store 0xDEADBEEF @0x10: four write beats then response
    issue(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("wst.we",    {31'd0, mem_we},    32'd1);
      chk("wst.addr",  {24'd0, mem_addr},  32'h10 + k);
      chk("wst.wdata", {24'd0, mem_wdata}, {24'd0, wexp[8*k +: 8]});
      chk("wst.ready", {31'd0, req_ready}, 32'd0);
      chk("wst.rv",    {31'd0, resp_valid}, 32'd0);
      step();
    end
    chk("wst.resp",  {31'd0, resp_valid}, 32'd1);
    chk("wst.err",   {31'd0, resp_err},   32'd0);
    chk("wst.rdata", resp_rdata,          32'd0);
    chk("wst.we_done", {31'd0, mem_we},   32'd0);
    chk("wst.mem",   {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
    step();
    chk("wst.idle", {31'd0, req_ready}, 32'd1);
    chk("wst.rv_off", {31'd0, resp_valid}, 32'd0);

    // Byte load @0x13 signed and unsigned
    issue(1'b0, 2'b00, 1'b0, 8'h13, 32'h0, 1'b0);
    chk("lbs.addr", {24'd0, mem_addr}, 32'h13);
    chk("lbs.we",   {31'd0, mem_we},   32'd0);
    chk("lbs.rv0",  {31'd0, resp_valid}, 32'd0);
    step();
    chk("lbs.rv",    {31'd0, resp_valid}, 32'd1);
    chk("lbs.rdata", resp_rdata, 32'hFFFFFFDE);
    step();
    issue(1'b0, 2'b00, 1'b1, 8'h13, 32'h0, 1'b0);
    step();
    chk("lbu.rv",    {31'd0, resp_valid}, 32'd1);
    chk("lbu.rdata", resp_rdata, 32'h000000DE);
    step();

    // Half loads @0x12 signed / unsigned
    issue(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, 1'b0);
    chk("lhs.addr0", {24'd0, mem_addr}, 32'h12);
    step();
    chk("lhs.addr1", {24'd0, mem_addr}, 32'h13);
    chk("lhs.rv0",   {31'd0, resp_valid}, 32'd0);
    step();
    chk("lhs.rv",    {31'd0, resp_valid}, 32'd1);
    chk("lhs.rdata", resp_rdata, 32'hFFFFDEAD);
    step();
    issue(1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 1'b0);
    step(); step();
    chk("lhu.rdata", resp_rdata, 32'h0000DEAD);
    step();

    // Misaligned half @0x11: immediate error response, no memory cycles
    issue(1'b0, 2'b01, 1'b0, 8'h11, 32'h0, 1'b0);
    chk("mis.rv",    {31'd0, resp_valid}, 32'd1);
    chk("mis.err",   {31'd0, resp_err},   32'd1);
    chk("mis.rdata", resp_rdata, 32'd0);
    chk("mis.we",    {31'd0, mem_we},     32'd0);
    step();
    chk("mis.idle",  {31'd0, req_ready},  32'd1);
    chk("mis.we2",   {31'd0, mem_we},     32'd0);

    // Illegal size store: error, memory untouched
    issue(1'b1, 2'b11, 1'b0, 8'h10, 32'h11223344, 1'b0);
    chk("ill.rv",  {31'd0, resp_valid}, 32'd1);
    chk("ill.err", {31'd0, resp_err},   32'd1);
    chk("ill.we",  {31'd0, mem_we},     32'd0);
    step();
    chk("ill.mem", {24'd0, mem[8'h10]}, 32'hEF);

    // Word store / load at top of memory
    issue(1'b1, 2'b10, 1'b0, 8'hFC, 32'h12345678, 1'b0);
    step(); step(); step(); step(); step();
    issue(1'b0, 2'b10, 1'b0, 8'hFC, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("top.addr", {24'd0, mem_addr}, 32'hFC + k);
      step();
    end
    chk("top.rv",    {31'd0, resp_valid}, 32'd1);
    chk("top.rdata", resp_rdata, 32'h12345678);
    chk("top.low",   {24'd0, mem[8'h00]}, 32'h00);
    step();
    issue(1'b0, 2'b00, 1'b0, 8'hFF, 32'h0, 1'b0);
    step();
    chk("top.lb", resp_rdata, 32'h00000012);
    step();

    // Reset during beat 2 of a word store
    issue(1'b1, 2'b10, 1'b0, 8'h20, 32'hA1B2C3D4, 1'b0);
    step(); step();
    chk("rsm.addr", {24'd0, mem_addr}, 32'h22);
    chk("rsm.we",   {31'd0, mem_we},   32'd1);
    #2 rst = 1'b0;
    #1;
    chk_idle_outputs("rsm");
    step();
    chk("rsm.rv_hold", {31'd0, resp_valid}, 32'd0);
    rst = 1'b1;
    step();
    chk("rsm.rv_a", {31'd0, resp_valid}, 32'd0);
    step();
    chk("rsm.rv_b", {31'd0, resp_valid}, 32'd0);
    chk("rsm.mem",  {8'd0, mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h0000C3D4);

    // Back-to-back: req_valid held high across two byte loads
    issue(1'b0, 2'b00, 1'b1, 8'h13, 32'h0, 1'b1);
    chk("b2b.ready_acc", {31'd0, req_ready}, 32'd0);
    step();
    chk("b2b.rv1",       {31'd0, resp_valid}, 32'd1);
    chk("b2b.ready_done", {31'd0, req_ready}, 32'd0);
    chk("b2b.rdata1",    resp_rdata, 32'h000000DE);
    step();
    chk("b2b.ready_idle", {31'd0, req_ready}, 32'd1);
    chk("b2b.busy_idle",  {31'd0, busy},      32'd0);
    req_addr = 8'h10; req_unsigned = 1'b0;
    step();
    req_valid = 1'b0;
    chk("b2b.busy2",  {31'd0, busy},      32'd1);
    chk("b2b.ready2", {31'd0, req_ready}, 32'd0);
    chk("b2b.addr2",  {24'd0, mem_addr},  32'h10);
    step();
    chk("b2b.rv2",    {31'd0, resp_valid}, 32'd1);
    chk("b2b.rdata2", resp_rdata, 32'hFFFFFFEF);
    step();
    chk("b2b.end",    {31'd0, req_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
